// File: rtl/mitm_logic_mc.sv
// Multi-channel MITM decision engine: evaluates one channel per cycle against its runtime
// configuration and publishes all substituted words together with a single done pulse.
`timescale 1ns/1ps
module mitm_logic_mc #(
  parameter int unsigned DATA_SIZE    = 8,
  parameter int unsigned NUM_CHANNELS = 2,
  parameter int unsigned CNT_WIDTH    = 8,
  localparam int unsigned CH_W        = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                                 sys_clk,
  input  logic                                 rst,
  input  logic                                 eval,
  input  logic [NUM_CHANNELS*DATA_SIZE-1:0]    real_data,
  input  logic                                 cfg_we,
  input  logic [CH_W-1:0]                      cfg_chan,
  input  logic [1:0]                           cfg_mode,
  input  logic [DATA_SIZE-1:0]                 cfg_match,
  input  logic [DATA_SIZE-1:0]                 cfg_value,
  input  logic [CNT_WIDTH-1:0]                 cfg_skip,
  output logic [NUM_CHANNELS*DATA_SIZE-1:0]    fake_data,
  output logic [NUM_CHANNELS-1:0]              fake_select,
  output logic                                 done_sig,
  output logic                                 busy
);

  localparam logic [1:0] MODE_PASS    = 2'd0;
  localparam logic [1:0] MODE_REPLACE = 2'd1;
  localparam logic [1:0] MODE_XOR     = 2'd2;
  localparam logic [1:0] MODE_MATCH   = 2'd3;

  typedef enum logic {S_IDLE, S_EVAL} state_t;

  state_t state_q, state_d;

  logic [1:0]                        mode_q  [NUM_CHANNELS];
  logic [DATA_SIZE-1:0]              match_q [NUM_CHANNELS];
  logic [DATA_SIZE-1:0]              value_q [NUM_CHANNELS];
  logic [CNT_WIDTH-1:0]              skip_q  [NUM_CHANNELS];
  logic [CNT_WIDTH-1:0]              cnt_q   [NUM_CHANNELS];

  logic [NUM_CHANNELS*DATA_SIZE-1:0] real_q;
  logic [NUM_CHANNELS*DATA_SIZE-1:0] shadow_data_q;
  logic [NUM_CHANNELS-1:0]           shadow_sel_q;
  logic [CH_W-1:0]                   idx_q;

  logic [DATA_SIZE-1:0]              cur_real_c;
  logic [DATA_SIZE-1:0]              res_data_c;
  logic                              res_sel_c;
  logic                              armed_c;
  logic                              last_c;
  logic                              start_c;
  logic                              cfg_ok_c;
  logic [CNT_WIDTH-1:0]              cnt_next_c;
  logic [NUM_CHANNELS*DATA_SIZE-1:0] shadow_data_c;
  logic [NUM_CHANNELS-1:0]           shadow_sel_c;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state plus the combinational result for the channel under evaluation.
  always_comb begin
    state_d       = state_q;
    cur_real_c    = real_q[32'(idx_q)*DATA_SIZE +: DATA_SIZE];
    armed_c       = (cnt_q[idx_q] >= skip_q[idx_q]);
    res_data_c    = cur_real_c;
    res_sel_c     = 1'b0;
    last_c        = (idx_q == CH_W'(NUM_CHANNELS - 1));
    start_c       = (state_q == S_IDLE) && eval;
    cfg_ok_c      = (state_q == S_IDLE) && cfg_we && (32'(cfg_chan) < NUM_CHANNELS);
    cnt_next_c    = (cnt_q[idx_q] == {CNT_WIDTH{1'b1}}) ? cnt_q[idx_q]
                                                        : cnt_q[idx_q] + CNT_WIDTH'(1);
    shadow_data_c = shadow_data_q;
    shadow_sel_c  = shadow_sel_q;

    if (armed_c) begin
      case (mode_q[idx_q])
        MODE_PASS: begin
          res_data_c = cur_real_c;
          res_sel_c  = 1'b0;
        end
        MODE_REPLACE: begin
          res_data_c = value_q[idx_q];
          res_sel_c  = 1'b1;
        end
        MODE_XOR: begin
          res_data_c = cur_real_c ^ value_q[idx_q];
          res_sel_c  = 1'b1;
        end
        MODE_MATCH: begin
          if (cur_real_c == match_q[idx_q]) begin
            res_data_c = value_q[idx_q];
            res_sel_c  = 1'b1;
          end
        end
        default: begin
          res_data_c = cur_real_c;
          res_sel_c  = 1'b0;
        end
      endcase
    end

    shadow_data_c[32'(idx_q)*DATA_SIZE +: DATA_SIZE] = res_data_c;
    shadow_sel_c[idx_q]                               = res_sel_c;

    case (state_q)
      S_IDLE:  if (eval) state_d = S_EVAL;
      S_EVAL:  if (last_c) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Configuration, counters, shadow registers and published outputs.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_CHANNELS); i++) begin
        mode_q[i]  <= MODE_PASS;
        match_q[i] <= '0;
        value_q[i] <= '0;
        skip_q[i]  <= '0;
        cnt_q[i]   <= '0;
      end
      real_q        <= '0;
      shadow_data_q <= '0;
      shadow_sel_q  <= '0;
      idx_q         <= '0;
      fake_data     <= '0;
      fake_select   <= '0;
      done_sig      <= 1'b0;
      busy          <= 1'b0;
    end else begin
      done_sig <= 1'b0;

      // Config lands on the same edge an eval starts, so that eval sees it.
      if (cfg_ok_c) begin
        mode_q[cfg_chan]  <= cfg_mode;
        match_q[cfg_chan] <= cfg_match;
        value_q[cfg_chan] <= cfg_value;
        skip_q[cfg_chan]  <= cfg_skip;
        cnt_q[cfg_chan]   <= '0;
      end

      if (start_c) begin
        real_q <= real_data;
        idx_q  <= '0;
        busy   <= 1'b1;
      end

      if (state_q == S_EVAL) begin
        shadow_data_q <= shadow_data_c;
        shadow_sel_q  <= shadow_sel_c;
        cnt_q[idx_q]  <= cnt_next_c;
        idx_q         <= idx_q + CH_W'(1);
        if (last_c) begin
          fake_data   <= shadow_data_c;
          fake_select <= shadow_sel_c;
          done_sig    <= 1'b1;
          busy        <= 1'b0;
          idx_q       <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mitm_logic_mc.sv
// Self-checking bench for mitm_logic_mc (2 channels, 8-bit words) with a per-eval reference model.
`timescale 1ns/1ps
module tb_mitm_logic_mc;

  logic        sys_clk = 1'b0;
  logic        rst;
  logic        eval;
  logic [15:0] real_data;
  logic        cfg_we;
  logic        cfg_chan;
  logic [1:0]  cfg_mode;
  logic [7:0]  cfg_match;
  logic [7:0]  cfg_value;
  logic [7:0]  cfg_skip;
  logic [15:0] fake_data;
  logic [1:0]  fake_select;
  logic        done_sig;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          mode_m  [2];
  logic [7:0]  match_m [2];
  logic [7:0]  value_m [2];
  int          skip_m  [2];
  int          cnt_m   [2];
  logic [15:0] pub_data;
  logic [1:0]  pub_sel;

  mitm_logic_mc dut (
    .sys_clk(sys_clk), .rst(rst), .eval(eval), .real_data(real_data),
    .cfg_we(cfg_we), .cfg_chan(cfg_chan), .cfg_mode(cfg_mode), .cfg_match(cfg_match),
    .cfg_value(cfg_value), .cfg_skip(cfg_skip), .fake_data(fake_data),
    .fake_select(fake_select), .done_sig(done_sig), .busy(busy)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      mode_m[c] = 0; match_m[c] = 8'h00; value_m[c] = 8'h00; skip_m[c] = 0; cnt_m[c] = 0;
    end
    pub_data = 16'h0000;
    pub_sel  = 2'b00;
  endtask

  task automatic model_cfg(input int ch, input int mode, input logic [7:0] m,
                           input logic [7:0] v, input int skip);
    mode_m[ch] = mode; match_m[ch] = m; value_m[ch] = v; skip_m[ch] = skip; cnt_m[ch] = 0;
  endtask

  // Apply the channel rules to one eval and advance the model counters.
  task automatic model_eval(input logic [7:0] d0, input logic [7:0] d1,
                            output logic [15:0] ed, output logic [1:0] es);
    logic [7:0] w;
    for (int c = 0; c < 2; c++) begin
      w = (c == 0) ? d0 : d1;
      ed[c*8 +: 8] = w;
      es[c] = 1'b0;
      if (cnt_m[c] >= skip_m[c]) begin
        if (mode_m[c] == 1) begin ed[c*8 +: 8] = value_m[c]; es[c] = 1'b1; end
        else if (mode_m[c] == 2) begin ed[c*8 +: 8] = w ^ value_m[c]; es[c] = 1'b1; end
        else if (mode_m[c] == 3 && w == match_m[c]) begin
          ed[c*8 +: 8] = value_m[c]; es[c] = 1'b1;
        end
      end
      if (cnt_m[c] < 255) cnt_m[c]++;
    end
  endtask

  task automatic drive_cfg(input int ch, input int mode, input logic [7:0] m,
                           input logic [7:0] v, input int skip);
    cfg_chan = ch[0]; cfg_mode = mode[1:0]; cfg_match = m; cfg_value = v;
    cfg_skip = skip[7:0]; cfg_we = 1'b1;
    @(posedge sys_clk); #1;
    cfg_we = 1'b0;
    model_cfg(ch, mode, m, v, skip);
  endtask

  // Issue one eval from IDLE and check busy/done timing and the published result.
  task automatic run_eval(input logic [7:0] d0, input logic [7:0] d1, input string tag);
    logic [15:0] ed;
    logic [1:0]  es;
    model_eval(d0, d1, ed, es);
    real_data = {d1, d0};
    eval = 1'b1;
    @(posedge sys_clk); #1;
    eval = 1'b0; cfg_we = 1'b0;
    checks++;
    if (busy !== 1'b1 || done_sig !== 1'b0) begin
      errors++;
      $display("FAIL %s t0: busy=%b done=%b required busy=1 done=0", tag, busy, done_sig);
    end
    @(posedge sys_clk); #1;
    checks++;
    if (busy !== 1'b1 || done_sig !== 1'b0 || fake_data !== pub_data || fake_select !== pub_sel) begin
      errors++;
      $display("FAIL %s t1: busy=%b done=%b data=%h sel=%b required 1 0 %h %b",
               tag, busy, done_sig, fake_data, fake_select, pub_data, pub_sel);
    end
    @(posedge sys_clk); #1;
    checks++;
    if (busy !== 1'b0 || done_sig !== 1'b1) begin
      errors++;
      $display("FAIL %s t2: busy=%b done=%b required busy=0 done=1", tag, busy, done_sig);
    end
    checks++;
    if (fake_data !== ed || fake_select !== es) begin
      errors++;
      $display("FAIL %s result: data=%h sel=%b required data=%h sel=%b",
               tag, fake_data, fake_select, ed, es);
    end
    pub_data = ed;
    pub_sel  = es;
  endtask

  task automatic test_reset();
    rst = 1'b1; eval = 1'b0; cfg_we = 1'b0; cfg_chan = 1'b0; cfg_mode = 2'd0;
    cfg_match = 8'h00; cfg_value = 8'h00; cfg_skip = 8'h00; real_data = 16'h0000;
    model_reset();
    repeat (2) @(posedge sys_clk);
    #1;
    checks++;
    if (fake_data !== 16'h0 || fake_select !== 2'b0 || done_sig !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset: data=%h sel=%b done=%b busy=%b required all zero",
               fake_data, fake_select, done_sig, busy);
    end
    rst = 1'b0;
    @(posedge sys_clk); #1;
  endtask

  task automatic test_pass();
    run_eval(8'ha3, 8'h01, "pass");
    @(posedge sys_clk); #1;
    checks++;
    if (done_sig !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL pass_done_width: done=%b busy=%b required 0 0", done_sig, busy);
    end
  endtask

  task automatic test_replace_xor();
    drive_cfg(0, 1, 8'h00, 8'h5a, 0);
    drive_cfg(1, 2, 8'h00, 8'hff, 0);
    run_eval(8'ha3, 8'h01, "replace_xor");
  endtask

  task automatic test_match();
    drive_cfg(0, 3, 8'h40, 8'h00, 0);
    run_eval(8'h40, 8'h10, "match_hit");
    run_eval(8'h41, 8'h10, "match_miss");
  endtask

  task automatic test_skip();
    drive_cfg(1, 1, 8'h00, 8'h77, 2);
    run_eval(8'h00, 8'hff, "skip_0");
    run_eval(8'h00, 8'hff, "skip_1");
    run_eval(8'h00, 8'hff, "skip_2");
    drive_cfg(1, 1, 8'h00, 8'h77, 2);
    run_eval(8'h00, 8'hff, "skip_cleared");
  endtask

  task automatic test_busy_ignore();
    logic [15:0] ed;
    logic [1:0]  es;
    drive_cfg(0, 0, 8'h00, 8'h00, 0);
    drive_cfg(1, 2, 8'h00, 8'h0f, 0);
    model_eval(8'h12, 8'h34, ed, es);
    real_data = 16'h3412; eval = 1'b1;
    @(posedge sys_clk); #1;
    // Hold eval and a config write through the busy window, including the done edge.
    cfg_chan = 1'b0; cfg_mode = 2'd1; cfg_value = 8'h99; cfg_skip = 8'h00; cfg_we = 1'b1;
    real_data = 16'hbeef;
    repeat (2) @(posedge sys_clk);
    #1;
    eval = 1'b0; cfg_we = 1'b0;
    checks++;
    if (done_sig !== 1'b1 || fake_data !== ed || fake_select !== es) begin
      errors++;
      $display("FAIL busy_ignore_result: done=%b data=%h sel=%b required 1 %h %b",
               done_sig, fake_data, fake_select, ed, es);
    end
    pub_data = ed; pub_sel = es;
    @(posedge sys_clk); #1;
    checks++;
    if (busy !== 1'b0 || done_sig !== 1'b0) begin
      errors++;
      $display("FAIL busy_ignore_restart: busy=%b done=%b required 0 0", busy, done_sig);
    end
    run_eval(8'h55, 8'hf0, "busy_ignore_cfg");
  endtask

  task automatic test_same_edge();
    cfg_chan = 1'b0; cfg_mode = 2'd2; cfg_match = 8'h00; cfg_value = 8'h3c; cfg_skip = 8'h00;
    cfg_we = 1'b1;
    model_cfg(0, 2, 8'h00, 8'h3c, 0);
    run_eval(8'hc3, 8'h00, "same_edge");
  endtask

  task automatic test_saturate();
    drive_cfg(0, 1, 8'h00, 8'haa, 255);
    drive_cfg(1, 0, 8'h00, 8'h00, 0);
    for (int n = 0; n < 258; n++) run_eval(8'h11, 8'h22, $sformatf("sat_%0d", n));
  endtask

  task automatic test_mid_reset();
    real_data = 16'h0102; eval = 1'b1;
    @(posedge sys_clk); #1;
    eval = 1'b0;
    @(posedge sys_clk); #1;
    rst = 1'b1;
    #0.5;
    checks++;
    if (fake_data !== 16'h0 || fake_select !== 2'b0 || busy !== 1'b0 || done_sig !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: data=%h sel=%b busy=%b done=%b required all zero",
               fake_data, fake_select, busy, done_sig);
    end
    #0.5;
    rst = 1'b0;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      @(posedge sys_clk); #1;
      checks++;
      if (done_sig !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset_no_done: cycle=%0d done=%b busy=%b required 0 0",
                 k, done_sig, busy);
      end
    end
    run_eval(8'ha3, 8'h01, "post_reset");
  endtask

  task automatic test_random();
    logic [7:0] d [2];
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) == 0)
        drive_cfg($urandom_range(0, 1), $urandom_range(0, 3), 8'($urandom),
                  8'($urandom), $urandom_range(0, 3));
      for (int c = 0; c < 2; c++)
        d[c] = ($urandom_range(0, 1) == 0) ? match_m[c] : 8'($urandom);
      run_eval(d[0], d[1], $sformatf("rand_%0d", n));
    end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_replace_xor();
    test_match();
    test_skip();
    test_busy_ignore();
    test_same_edge();
    test_saturate();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
